uart_baud_gen: RTL

Parametrised baud-tick generator for the UART TX and RX engines. It replaces the fixed four-rate, toggling-clock generator with two single-cycle clock-enable ticks:
- `rx_tick` at OVERSAMPLE × baud, re-phasable by the receiver on start-bit detection.
- `tx_tick` at 1 × baud.

It supports eight rate selections, including one runtime-programmable divisor. It sits between the register block and the TX/RX engines, all in the `clk` domain.

---
 rtl/uart_baud_pkg.sv | 28 ++
 rtl/uart_tick_div.sv | 78 +++++++
 rtl/uart_baud_gen.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/uart_baud_pkg.sv
// Shared constants for the UART baud-tick generator: rate-select encoding,
// preset baud rates, fraction width and the elaboration-time divisor function.
package uart_baud_pkg;

   localparam int FRAC_W = 4;

   localparam logic [2:0] BAUD_SEL_2400   = 3'd0;
   localparam logic [2:0] BAUD_SEL_4800   = 3'd1;
   localparam logic [2:0] BAUD_SEL_9600   = 3'd2;
   localparam logic [2:0] BAUD_SEL_19200  = 3'd3;
   localparam logic [2:0] BAUD_SEL_38400  = 3'd4;
   localparam logic [2:0] BAUD_SEL_57600  = 3'd5;
   localparam logic [2:0] BAUD_SEL_115200 = 3'd6;
   localparam logic [2:0] BAUD_SEL_CUSTOM = 3'd7;

   localparam int unsigned BAUD_RATE [7] = '{2400, 4800, 9600, 19200, 38400, 57600, 115200};

   // Rounded clk_hz / (baud * os); callers pre-scale clk_hz for fixed-point results.
   function automatic longint unsigned calc_div(input longint unsigned clk_hz,
                                                input longint unsigned baud,
                                                input longint unsigned os);
      longint unsigned den;
      den = baud * os;
      if (den == 0) return 0;
      return (clk_hz + den / 2) / den;
   endfunction

endpackage

// File: rtl/uart_tick_div.sv
// Loadable modulo-D counter with synchronous clear; pulses wrap on D-1 -> 0.
// With UART_BAUD_FRAC_EN a 1/16 phase accumulator stretches a period on carry.
module uart_tick_div
   import uart_baud_pkg::*;
#(
   parameter int DIV_W = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             clr,
   input  logic [DIV_W-1:0] div,
`ifdef UART_BAUD_FRAC_EN
   input  logic [FRAC_W-1:0] frac,
`endif
   output logic             wrap
);

   logic [DIV_W-1:0] cnt_q, cnt_d;
   logic             term;
`ifdef UART_BAUD_FRAC_EN
   logic [FRAC_W-1:0] acc_q, acc_d;
   logic              ext_q, ext_d;
   logic [FRAC_W:0]   sum;
`endif

   always_comb begin
      term  = (cnt_q >= div - DIV_W'(1));
      cnt_d = cnt_q;
      wrap  = 1'b0;
`ifdef UART_BAUD_FRAC_EN
      acc_d = acc_q;
      ext_d = ext_q;
      sum   = {1'b0, acc_q} + {1'b0, frac};
`endif
      if (clr) begin
         cnt_d = '0;
`ifdef UART_BAUD_FRAC_EN
         acc_d = '0;
         ext_d = 1'b0;
`endif
      end else if (term) begin
`ifdef UART_BAUD_FRAC_EN
         // A carry holds the terminal count for one extra cycle before wrapping.
         if (!ext_q && sum[FRAC_W]) begin
            ext_d = 1'b1;
            acc_d = sum[FRAC_W-1:0];
         end else begin
            cnt_d = '0;
            wrap  = 1'b1;
            ext_d = 1'b0;
            if (!ext_q) acc_d = sum[FRAC_W-1:0];
         end
`else
         cnt_d = '0;
         wrap  = 1'b1;
`endif
      end else begin
         cnt_d = cnt_q + DIV_W'(1);
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt_q <= '0;
`ifdef UART_BAUD_FRAC_EN
         acc_q <= '0;
         ext_q <= 1'b0;
`endif
      end else begin
         cnt_q <= cnt_d;
`ifdef UART_BAUD_FRAC_EN
         acc_q <= acc_d;
         ext_q <= ext_d;
`endif
      end
   end

endmodule

// File: rtl/uart_baud_gen.sv
// Baud-tick generator: rx_tick every D cycles, tx_tick every D*OVERSAMPLE cycles.
// Optional fractional divisors via `define UART_BAUD_FRAC_EN (adds div_frac).
module uart_baud_gen
   import uart_baud_pkg::*;
#(
   parameter longint unsigned CLK_HZ     = 50_000_000,
   parameter int              OVERSAMPLE = 16,
   parameter int              DIV_W      = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             en,
   input  logic [2:0]       baud_sel,
   input  logic [DIV_W-1:0] div_custom,
`ifdef UART_BAUD_FRAC_EN
   input  logic [FRAC_W-1:0] div_frac,
`endif
   input  logic             rx_sync,
   output logic             rx_tick,
   output logic             tx_tick,
   output logic             rate_chg
);

`ifdef UART_BAUD_FRAC_EN
   localparam int FSH = FRAC_W;
`else
   localparam int FSH = 0;
`endif
   localparam int PW  = DIV_W + FSH;
   localparam int OSW = $clog2(OVERSAMPLE);
   localparam logic [OSW-1:0] OS_LAST = OSW'(OVERSAMPLE - 1);

   typedef logic [7:0][PW-1:0] preset_t;

   // Presets carry FSH fractional bits, saturated to the divisor range, minimum 1.0.
   function automatic preset_t build_presets();
      preset_t         p;
      longint unsigned v;
      longint unsigned vmax;
      longint unsigned vmin;
      vmax = (64'd1 << PW) - 64'd1;
      vmin = 64'd1 << FSH;
      p    = '0;
      p[7] = PW'(vmin);
      for (int i = 0; i < 7; i++) begin
         v = calc_div(CLK_HZ << FSH, longint'(BAUD_RATE[i]), longint'(OVERSAMPLE));
         if (v > vmax) v = vmax;
         if (v < vmin) v = vmin;
         p[i] = PW'(v);
      end
      return p;
   endfunction

   localparam preset_t PRESETS = build_presets();

   logic [DIV_W-1:0] dec_div, div_q;
`ifdef UART_BAUD_FRAC_EN
   logic [FRAC_W-1:0] dec_frac, frac_q;
`endif
   logic [OSW-1:0] os_q, os_d;
   logic           rx_tick_q, rx_tick_d;
   logic           tx_tick_q, tx_tick_d;
   logic           rate_chg_q, rate_chg_d;
   logic           chg, rx_clr, tx_clr, rx_wrap, tx_wrap;

   always_comb begin
      dec_div = DIV_W'(PRESETS[baud_sel] >> FSH);
`ifdef UART_BAUD_FRAC_EN
      dec_frac = PRESETS[baud_sel][FRAC_W-1:0];
`endif
      if (baud_sel == BAUD_SEL_CUSTOM) begin
         dec_div = (div_custom < DIV_W'(2)) ? DIV_W'(1) : div_custom;
`ifdef UART_BAUD_FRAC_EN
         dec_frac = div_frac;
`endif
      end
   end

`ifdef UART_BAUD_FRAC_EN
   assign chg = (dec_div != div_q) || (dec_frac != frac_q);
`else
   assign chg = (dec_div != div_q);
`endif
   assign rx_clr = chg || !en || rx_sync;
   assign tx_clr = chg || !en;

   uart_tick_div #(.DIV_W(DIV_W)) u_rx_div (
      .clk   (clk),
      .reset (reset),
      .clr   (rx_clr),
      .div   (div_q),
`ifdef UART_BAUD_FRAC_EN
      .frac  (frac_q),
`endif
      .wrap  (rx_wrap)
   );

   uart_tick_div #(.DIV_W(DIV_W)) u_tx_div (
      .clk   (clk),
      .reset (reset),
      .clr   (tx_clr),
      .div   (div_q),
`ifdef UART_BAUD_FRAC_EN
      .frac  (frac_q),
`endif
      .wrap  (tx_wrap)
   );

   always_comb begin
      os_d = os_q;
      if (tx_clr) begin
         os_d = '0;
      end else if (tx_wrap) begin
         os_d = (os_q == OS_LAST) ? '0 : os_q + OSW'(1);
      end
      // Wrap outputs are already suppressed by the clears.
      rx_tick_d  = rx_wrap;
      tx_tick_d  = tx_wrap && (os_q == OS_LAST);
      rate_chg_d = chg;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         div_q      <= dec_div;
`ifdef UART_BAUD_FRAC_EN
         frac_q     <= dec_frac;
`endif
         os_q       <= '0;
         rx_tick_q  <= 1'b0;
         tx_tick_q  <= 1'b0;
         rate_chg_q <= 1'b0;
      end else begin
         div_q      <= dec_div;
`ifdef UART_BAUD_FRAC_EN
         frac_q     <= dec_frac;
`endif
         os_q       <= os_d;
         rx_tick_q  <= rx_tick_d;
         tx_tick_q  <= tx_tick_d;
         rate_chg_q <= rate_chg_d;
      end
   end

   assign rx_tick  = rx_tick_q;
   assign tx_tick  = tx_tick_q;
   assign rate_chg = rate_chg_q;

endmodule
